mlp_eval_ctrl: RTL and testbench
================================

# mlp_eval_ctrl

Run controller and scoreboard for batch evaluation of the MLP datapath. It steps through a programmable number of test cases and issues a start pulse per case. It waits for the datapath's result handshake, or a timeout, and compares the predicted label with the reference label. It accumulates correct, total and timeout counts, plus optional per-class hit counts. It sits between the test-case/label memories and the MLP datapath and replaces free-running address and accuracy counting with an explicit handshaked sequence.

## Interface
Parameters:
- CLASS_W, 4, label width
- NUM_CLASSES, 10, number of valid classes (labels 0..NUM_CLASSES-1)
- CASE_W, 10, width of case index and all count outputs
- TMO_W, 8, width of timeout timer
- TIMEOUT, 200, max WAIT cycles per case; must satisfy 1 ≤ TIMEOUT ≤ 2^TMO_W-1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- start  in  1  begin a run; sampled only in IDLE
- num_cases  in  CASE_W  cases in this run; latched on accepted start
- addr  out  CASE_W  current case index, drives data/label memory read address
- infer_start  out  1  one-cycle pulse to datapath
- infer_done  in  1  datapath result valid; sampled only in WAIT
- pred_label  in  CLASS_W  datapath prediction, valid with infer_done
- ref_label  in  CLASS_W  expected label for addr (combinational memory read)
- busy  out  1  high in every state except IDLE
- run_done  out  1  one-cycle pulse at end of run
- correct  out  CASE_W  correct predictions this run
- total  out  CASE_W  cases evaluated this run
- timeouts  out  CASE_W  cases ended by timeout
- class_hits  out  NUM_CLASSES*CASE_W  per-class correct counts, class k at [k*CASE_W +: CASE_W]

## Operation
- States: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE, start=1:
  - latch num_cases into nc_q; clear addr, correct, total, timeouts and class_hits.
  - go to DONE if num_cases==0, else go to ISSUE.
- ISSUE: infer_start=1 for this cycle only; clear timer; go to WAIT.
- WAIT:
  - infer_done=1: register pred_label into pred_q and set tmo_q=0; go to CHECK.
  - infer_done=0 and timer==TIMEOUT-1: set tmo_q=1; go to CHECK.
  - otherwise timer+1.
  - infer_done and timeout in the same cycle: done wins.
- CHECK:
  - eq = !tmo_q && (pred_q==ref_label) && (ref_label<NUM_CLASSES).
  - total+1; correct+eq; timeouts+tmo_q; class_hits[ref_label]+eq.
  - If addr==nc_q-1, go to DONE; else addr+1 and go to ISSUE.
- DONE: run_done=1 for one cycle; go to IDLE.
- Results hold in IDLE until the next accepted start.
- start while busy is ignored; num_cases changes after latch are ignored.
- infer_done outside WAIT is ignored; a late done after a timeout is dropped.
- addr is stable from ISSUE through CHECK, so ref_label is read at the same index as the data.
- Arithmetic is unsigned. Counts cannot overflow because total ≤ nc_q ≤ 2^CASE_W-1.

## Timing
- Reset (rst=0), asynchronous, any state:
  - state=IDLE; addr, correct, total, timeouts and class_hits = 0.
  - busy, infer_start, run_done = 0.
  - Reset mid-run abandons the run; no run_done is produced.
- start sampled at edge N → busy=1 from N+1; infer_start high during cycle N+1.
- Per case: 1 ISSUE + k WAIT + 1 CHECK cycles, where infer_done is first seen in WAIT cycle k (k≥1). Minimum 3 cycles per case.
- Timed-out case: 1 + TIMEOUT + 1 cycles.
- Counters update at the edge leaving CHECK.
- run_done is asserted in the cycle after the last CHECK; busy drops with the edge leaving DONE.
- num_cases==0: start → DONE → IDLE; run_done 1 cycle after start, all counts 0.

## Configuration
- MLP_EVAL_CLASS_STATS_EN defined:
  - per-class hit counters are implemented and updated in CHECK.
- Not defined:
  - no per-class registers; class_hits tied to 0.
  - all other behaviour is identical.

## Test plan
- Reset mid-WAIT: assert rst=0 during case 3 of 8 → all outputs 0 immediately, state IDLE, no run_done; a subsequent start runs 8 cases cleanly.
- Basic run: num_cases=5, datapath returns done 2 cycles after each infer_start, predictions match on cases 0,2,4 → correct=3, total=5, timeouts=0, 5 infer_start pulses, run_done 1 cycle.
- Timeout: TIMEOUT=4, case 1 of 3 never answers → WAIT exits after exactly 4 cycles; timeouts=1, total=3, correct excludes case 1; a late infer_done is ignored.
- Same-cycle done and timeout: infer_done arrives in the 4th WAIT cycle with TIMEOUT=4 → counted as done, timeouts=0.
- Control edges:
  - num_cases=0 → run_done on the next cycle, counts 0.
  - start pulsed while busy → no restart, nc_q unchanged.
  - ref_label=12 with NUM_CLASSES=10 → counted in total, not in correct.
- Class stats (macro on): 6 cases with labels 2,2,7,7,7,0, all correct → class_hits[2]=2, [7]=3, [0]=1, others 0. With the macro off → class_hits=0.

Source files
------------

// File: rtl/mlp_eval_ctrl_if.sv
// ============================================================================
// Module   : mlp_eval_ctrl_if
// Brief    : Handshake bundle between the evaluation controller and the MLP
//            datapath / test-case memories.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mlp_eval_ctrl_if #(
   parameter int CLASS_W = 4,
   parameter int CASE_W  = 10
);
   logic [CASE_W-1:0]  addr;
   logic               infer_start;
   logic               infer_done;
   logic [CLASS_W-1:0] pred_label;
   logic [CLASS_W-1:0] ref_label;

   modport master (
      output addr,
      output infer_start,
      input  infer_done,
      input  pred_label,
      input  ref_label
   );

   modport slave (
      input  addr,
      input  infer_start,
      output infer_done,
      output pred_label,
      output ref_label
   );
endinterface

`default_nettype wire

// File: rtl/mlp_eval_ctrl.sv
// ============================================================================
// Module   : mlp_eval_ctrl
// Brief    : Batch evaluation run controller and accuracy scoreboard.
//            MLP_EVAL_CLASS_STATS_EN enables the per-class hit counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mlp_eval_ctrl #(
   parameter int CLASS_W     = 4,
   parameter int NUM_CLASSES = 10,
   parameter int CASE_W      = 10,
   parameter int TMO_W       = 8,
   parameter int TIMEOUT     = 200
) (
   input  wire                           clk,
   input  wire                           rst,
   input  wire                           start,
   input  wire  [CASE_W-1:0]             num_cases,
   mlp_eval_ctrl_if.master               dp,
   output logic                          busy,
   output logic                          run_done,
   output logic [CASE_W-1:0]             correct,
   output logic [CASE_W-1:0]             total,
   output logic [CASE_W-1:0]             timeouts,
   output logic [NUM_CLASSES*CASE_W-1:0] class_hits
);

   localparam logic [TMO_W-1:0]   c_tmo_last    = TMO_W'(TIMEOUT - 1);
   localparam logic [CLASS_W:0]   c_num_classes = (CLASS_W + 1)'(NUM_CLASSES);
   localparam logic [CASE_W-1:0]  c_case_one    = CASE_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CASE_W-1:0]   r_nc;
   logic [CASE_W-1:0]   r_addr;
   logic [TMO_W-1:0]    r_timer;
   logic [CLASS_W-1:0]  r_pred;
   logic                r_tmo;
   logic [CASE_W-1:0]   r_correct;
   logic [CASE_W-1:0]   r_total;
   logic [CASE_W-1:0]   r_timeouts;
   logic                w_eq;
   logic                w_last;

   // Out-of-range reference labels never count as correct.
   assign w_eq   = !r_tmo && (r_pred == dp.ref_label) &&
                   ({1'b0, dp.ref_label} < c_num_classes);
   assign w_last = (r_addr == (r_nc - c_case_one));

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b1;
      run_done    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) w_state_nxt = (num_cases == '0) ? S_DONE : S_ISSUE;
         end
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (dp.infer_done || (r_timer == c_tmo_last)) w_state_nxt = S_CHECK;
         end
         S_CHECK: w_state_nxt = w_last ? S_DONE : S_ISSUE;
         S_DONE: begin
            run_done    = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_nc       <= '0;
         r_addr     <= '0;
         r_timer    <= '0;
         r_pred     <= '0;
         r_tmo      <= 1'b0;
         r_correct  <= '0;
         r_total    <= '0;
         r_timeouts <= '0;
      end else begin
         r_state <= w_state_nxt;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_nc       <= num_cases;
                  r_addr     <= '0;
                  r_correct  <= '0;
                  r_total    <= '0;
                  r_timeouts <= '0;
               end
            end
            S_ISSUE: r_timer <= '0;
            S_WAIT: begin
               // A result arriving on the final timer cycle still counts.
               if (dp.infer_done) begin
                  r_pred <= dp.pred_label;
                  r_tmo  <= 1'b0;
               end else if (r_timer == c_tmo_last) begin
                  r_tmo  <= 1'b1;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_CHECK: begin
               r_total    <= r_total + c_case_one;
               r_correct  <= r_correct + CASE_W'(w_eq);
               r_timeouts <= r_timeouts + CASE_W'(r_tmo);
               if (!w_last) r_addr <= r_addr + c_case_one;
            end
            default: ;
         endcase
      end
   end

   assign dp.addr        = r_addr;
   assign dp.infer_start = (r_state == S_ISSUE);
   assign correct        = r_correct;
   assign total          = r_total;
   assign timeouts       = r_timeouts;

`ifdef MLP_EVAL_CLASS_STATS_EN
   logic w_clear;
   logic w_hit_en;

   assign w_clear  = (r_state == S_IDLE) && start;
   assign w_hit_en = (r_state == S_CHECK) && w_eq;

   generate
      for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_class
         logic [CASE_W-1:0] r_hits;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_hits <= '0;
            end else if (w_clear) begin
               r_hits <= '0;
            end else if (w_hit_en && (dp.ref_label == CLASS_W'(k))) begin
               r_hits <= r_hits + c_case_one;
            end
         end

         assign class_hits[k*CASE_W +: CASE_W] = r_hits;
      end
   endgenerate
`else
   assign class_hits = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mlp_eval_ctrl.sv
// ============================================================================
// Module   : tb_mlp_eval_ctrl
// Brief    : Scoreboard bench for mlp_eval_ctrl with a latency-programmable
//            datapath responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mlp_eval_ctrl;

   localparam int CLASS_W     = 4;
   localparam int NUM_CLASSES = 10;
   localparam int CASE_W      = 10;
   localparam int TMO_W       = 8;
   localparam int TIMEOUT     = 4;
   localparam int HW          = NUM_CLASSES * CASE_W;

   typedef struct {
      logic [CASE_W-1:0] correct;
      logic [CASE_W-1:0] total;
      logic [CASE_W-1:0] timeouts;
      logic [HW-1:0]     hits;
      int                starts;
      int                cycles;
   } exp_t;

   logic              clk;
   logic              rst;
   logic              start;
   logic [CASE_W-1:0] num_cases;
   logic              busy;
   logic              run_done;
   logic [CASE_W-1:0] correct;
   logic [CASE_W-1:0] total;
   logic [CASE_W-1:0] timeouts;
   logic [HW-1:0]     class_hits;

   int                lat_tab  [16];
   logic [3:0]        pred_tab [16];
   logic [3:0]        ref_mem  [16];
   int                hv       [NUM_CLASSES];
   int                n_starts;
   int                checks;
   int                errors;
   exp_t              q[$];

   mlp_eval_ctrl_if #(.CLASS_W(CLASS_W), .CASE_W(CASE_W)) dp_if ();

   mlp_eval_ctrl #(
      .CLASS_W     (CLASS_W),
      .NUM_CLASSES (NUM_CLASSES),
      .CASE_W      (CASE_W),
      .TMO_W       (TMO_W),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .num_cases  (num_cases),
      .dp         (dp_if),
      .busy       (busy),
      .run_done   (run_done),
      .correct    (correct),
      .total      (total),
      .timeouts   (timeouts),
      .class_hits (class_hits)
   );

   assign dp_if.ref_label = ref_mem[dp_if.addr[3:0]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [HW-1:0] pack_hits();
      logic [HW-1:0] v;
      v = '0;
`ifdef MLP_EVAL_CLASS_STATS_EN
      for (int k = 0; k < NUM_CLASSES; k++) v[k*CASE_W +: CASE_W] = CASE_W'(hv[k]);
`endif
      return v;
   endfunction

   task automatic set_case(input int i, input int l, input int r, input int p);
      lat_tab[i]  = l;
      ref_mem[i]  = 4'(r);
      pred_tab[i] = 4'(p);
   endtask

   task automatic clear_hv();
      for (int k = 0; k < NUM_CLASSES; k++) hv[k] = 0;
   endtask

   // Datapath model: lat_tab[i]=k raises infer_done in WAIT cycle k; 0 never answers.
   initial begin
      int         cd;
      logic       pend;
      logic [3:0] p;
      cd = 0;
      pend = 1'b0;
      p = '0;
      dp_if.infer_done = 1'b0;
      dp_if.pred_label = '0;
      forever begin
         @(posedge clk);
         #1;
         dp_if.infer_done = 1'b0;
         if (!rst) begin
            pend = 1'b0;
         end else if (dp_if.infer_start) begin
            n_starts++;
            cd   = lat_tab[dp_if.addr[3:0]];
            p    = pred_tab[dp_if.addr[3:0]];
            pend = (cd > 0);
         end else if (pend) begin
            cd--;
            if (cd == 0) begin
               dp_if.infer_done = 1'b1;
               dp_if.pred_label = p;
               pend = 1'b0;
            end
         end
      end
   end

   // Monitor: pops one expected record on every run_done.
   initial begin
      int   bcnt;
      logic post;
      exp_t e;
      bcnt = 0;
      post = 1'b0;
      forever begin
         @(negedge clk);
         if (post) begin
            post = 1'b0;
            chk("run_done_width", HW'(run_done), HW'(0));
            chk("busy_after_done", HW'(busy), HW'(0));
         end
         if (!rst) begin
            bcnt = 0;
         end else begin
            if (busy) bcnt++;
            if (run_done) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_run_done: got 1 expected 0");
               end else begin
                  e = q.pop_front();
                  chk("correct",  HW'(correct),  HW'(e.correct));
                  chk("total",    HW'(total),    HW'(e.total));
                  chk("timeouts", HW'(timeouts), HW'(e.timeouts));
                  chk("class_hits", class_hits, e.hits);
                  chk("infer_starts", HW'(n_starts), HW'(e.starts));
                  chk("run_cycles", HW'(bcnt), HW'(e.cycles));
               end
               bcnt = 0;
               post = 1'b1;
            end
         end
      end
   end

   task automatic do_run(input int n, input int ec, input int et, input int eto,
                         input int est, input int ecyc, input bit poke);
      exp_t e;
      int   cyc;
      e.correct  = CASE_W'(ec);
      e.total    = CASE_W'(et);
      e.timeouts = CASE_W'(eto);
      e.hits     = pack_hits();
      e.starts   = est;
      e.cycles   = ecyc;
      q.push_back(e);
      n_starts = 0;
      @(negedge clk);
      start     = 1'b1;
      num_cases = CASE_W'(n);
      @(negedge clk);
      start = 1'b0;
      if (poke) begin
         @(negedge clk);
         start     = 1'b1;
         num_cases = CASE_W'(7);
         @(negedge clk);
         start = 1'b0;
      end
      cyc = 0;
      while (busy && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL run_timeout: busy still 1 after %0d cycles, expected 0", cyc);
      end
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      checks    = 0;
      errors    = 0;
      n_starts  = 0;
      rst       = 1'b0;
      start     = 1'b0;
      num_cases = '0;
      for (int i = 0; i < 16; i++) set_case(i, 1, 0, 0);
      clear_hv();
      repeat (3) @(negedge clk);
      chk("rst_busy",     HW'(busy),              HW'(0));
      chk("rst_run_done", HW'(run_done),          HW'(0));
      chk("rst_start",    HW'(dp_if.infer_start), HW'(0));
      chk("rst_addr",     HW'(dp_if.addr),        HW'(0));
      chk("rst_counts",   HW'({correct, total, timeouts}), HW'(0));
      chk("rst_hits",     class_hits,             HW'(0));
      rst = 1'b1;
      @(negedge clk);

      // Abandoned run: reset while case 3 of 8 waits.
      for (int i = 0; i < 8; i++) set_case(i, 2, i, i);
      start     = 1'b1;
      num_cases = CASE_W'(8);
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!(dp_if.infer_start && dp_if.addr == CASE_W'(3)) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("mid_total",   HW'(total),   HW'(3));
      chk("mid_correct", HW'(correct), HW'(3));
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("arst_busy",   HW'(busy),              HW'(0));
      chk("arst_addr",   HW'(dp_if.addr),        HW'(0));
      chk("arst_total",  HW'(total),             HW'(0));
      chk("arst_corr",   HW'(correct),           HW'(0));
      chk("arst_start",  HW'(dp_if.infer_start), HW'(0));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_rst_idle", HW'(busy), HW'(0));

      // Clean 8-case run after the reset.
      clear_hv();
      for (int k = 0; k < 8; k++) hv[k] = 1;
      do_run(8, 8, 8, 0, 8, 33, 1'b0);

      // Basic: 5 cases, done in WAIT cycle 2, matches on 0,2,4.
      set_case(0, 2, 3, 3);
      set_case(1, 2, 1, 0);
      set_case(2, 2, 4, 4);
      set_case(3, 2, 1, 2);
      set_case(4, 2, 5, 5);
      clear_hv();
      hv[3] = 1; hv[4] = 1; hv[5] = 1;
      do_run(5, 3, 5, 0, 5, 21, 1'b0);
      repeat (3) @(negedge clk);
      chk("hold_correct", HW'(correct), HW'(3));
      chk("hold_total",   HW'(total),   HW'(5));

      // Timeout on case 1; its late done lands in CHECK and is dropped.
      set_case(0, 1, 6, 6);
      set_case(1, 5, 6, 6);
      set_case(2, 1, 9, 9);
      clear_hv();
      hv[6] = 1; hv[9] = 1;
      do_run(3, 2, 3, 1, 3, 13, 1'b0);

      // Done on the last WAIT cycle beats the timeout.
      set_case(0, 4, 2, 2);
      set_case(1, 3, 8, 8);
      clear_hv();
      hv[2] = 1; hv[8] = 1;
      do_run(2, 2, 2, 0, 2, 12, 1'b0);

      // Zero-length run.
      clear_hv();
      do_run(0, 0, 0, 0, 0, 1, 1'b0);

      // Start pulsed while busy with a different num_cases.
      set_case(0, 1, 1, 1);
      set_case(1, 1, 2, 2);
      set_case(2, 1, 3, 3);
      clear_hv();
      hv[1] = 1; hv[2] = 1; hv[3] = 1;
      do_run(3, 3, 3, 0, 3, 10, 1'b1);

      // Out-of-range reference label.
      set_case(0, 1, 12, 12);
      set_case(1, 1, 5, 5);
      clear_hv();
      hv[5] = 1;
      do_run(2, 1, 2, 0, 2, 7, 1'b0);

      // Per-class accumulation.
      set_case(0, 1, 2, 2);
      set_case(1, 1, 2, 2);
      set_case(2, 1, 7, 7);
      set_case(3, 1, 7, 7);
      set_case(4, 1, 7, 7);
      set_case(5, 1, 0, 0);
      clear_hv();
      hv[2] = 2; hv[7] = 3; hv[0] = 1;
      do_run(6, 6, 6, 0, 6, 19, 1'b0);

      repeat (3) @(negedge clk);
      chk("queue_drained", HW'(q.size()), HW'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
